// File: rtl/sum_acc_pkg.sv
// Shared types and default widths for the sum accumulator slice.
package sum_acc_pkg;

    typedef enum logic {ACCUM, HOLD} sum_acc_state_t;

    localparam int SUM_ACC_SWIDTH = 9;
    localparam int SUM_ACC_CWIDTH = 4;

endpackage

// File: rtl/sum_acc_add.sv
// Accumulator adder with carry-out detect.
// SUM_ACC_SAT_EN: clamp the result to all-ones on carry-out instead of wrapping.
module sum_acc_add #(
    parameter int SWIDTH = 9,
    parameter int AWIDTH = 13
) (
    input  logic [AWIDTH-1:0] acc,
    input  logic [SWIDTH-1:0] sm,
    output logic [AWIDTH-1:0] sum,
    output logic              carry
);

    localparam int PAD = AWIDTH + 1 - SWIDTH;

    logic [AWIDTH:0] full;

    assign full  = {1'b0, acc} + {{PAD{1'b0}}, sm};
    assign carry = full[AWIDTH];

`ifdef SUM_ACC_SAT_EN
    // Once clamped, any further non-zero beat carries again, so the total stays pinned.
    assign sum = carry ? {AWIDTH{1'b1}} : full[AWIDTH-1:0];
`else
    assign sum = full[AWIDTH-1:0];
`endif

endmodule

// File: rtl/sum_accumulator.sv
// Accumulates COUNT adder sums per frame and presents the total on a valid/ready port.
// Saturating vs wrapping total is selected by SUM_ACC_SAT_EN (see sum_acc_add).
//   state | meaning
//   ACCUM | accepting beats into the running total
//   HOLD  | frame result presented, waiting for the consumer
module sum_accumulator
    import sum_acc_pkg::*;
#(
    parameter int SWIDTH = SUM_ACC_SWIDTH,
    parameter int COUNT  = 4,
    parameter int AWIDTH = SWIDTH + 4,
    parameter int CWIDTH = SUM_ACC_CWIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [SWIDTH-1:0] sm_r,
    input  logic              sm_zero_r,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [AWIDTH-1:0] acc,
    output logic [CWIDTH-1:0] zero_cnt,
    output logic              overflow
);

    localparam logic [CWIDTH-1:0] LAST_BEAT = CWIDTH'(COUNT - 1);

    sum_acc_state_t    state, state_nxt;
    logic [CWIDTH-1:0] cnt;
    logic [AWIDTH-1:0] acc_nxt;
    logic              carry;
    logic              accept;
    logic              take;

    sum_acc_add #(
        .SWIDTH (SWIDTH),
        .AWIDTH (AWIDTH)
    ) u_add (
        .acc   (acc),
        .sm    (sm_r),
        .sum   (acc_nxt),
        .carry (carry)
    );

    assign accept = in_valid & in_ready;
    assign take   = out_valid & out_ready;

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            ACCUM: begin
                in_ready = 1'b1;
                if (accept && cnt == LAST_BEAT) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = ACCUM;
                end
            end
            default: state_nxt = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ACCUM;
            acc      <= '0;
            zero_cnt <= '0;
            cnt      <= '0;
            overflow <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                acc      <= acc_nxt;
                zero_cnt <= zero_cnt + CWIDTH'(sm_zero_r);
                overflow <= overflow | carry;
                cnt      <= (cnt == LAST_BEAT) ? '0 : cnt + CWIDTH'(1);
            end else if (take) begin
                acc      <= '0;
                zero_cnt <= '0;
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sum_accumulator.sv
// Directed bench for sum_accumulator: default build, a 10-bit accumulator and COUNT=1.
module tb_sum_accumulator;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    // default instance
    logic        in_valid, in_ready, sm_zero_r, out_valid, out_ready, overflow;
    logic [8:0]  sm_r;
    logic [12:0] acc;
    logic [3:0]  zero_cnt;

    // AWIDTH=10 instance
    logic        v_in_valid, v_in_ready, v_out_valid, v_out_ready, v_overflow;
    logic [8:0]  v_sm_r;
    logic [9:0]  v_acc;
    logic [3:0]  v_zero_cnt;

    // COUNT=1 instance
    logic        c_in_valid, c_in_ready, c_sm_zero_r, c_out_valid, c_out_ready, c_overflow;
    logic [8:0]  c_sm_r;
    logic [12:0] c_acc;
    logic [3:0]  c_zero_cnt;

    sum_accumulator u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .sm_r(sm_r), .sm_zero_r(sm_zero_r), .out_valid(out_valid), .out_ready(out_ready),
        .acc(acc), .zero_cnt(zero_cnt), .overflow(overflow)
    );

    sum_accumulator #(.AWIDTH(10)) u_dut_w10 (
        .clk(clk), .rst(rst), .in_valid(v_in_valid), .in_ready(v_in_ready),
        .sm_r(v_sm_r), .sm_zero_r(1'b0), .out_valid(v_out_valid), .out_ready(v_out_ready),
        .acc(v_acc), .zero_cnt(v_zero_cnt), .overflow(v_overflow)
    );

    sum_accumulator #(.COUNT(1)) u_dut_c1 (
        .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .sm_r(c_sm_r), .sm_zero_r(c_sm_zero_r), .out_valid(c_out_valid), .out_ready(c_out_ready),
        .acc(c_acc), .zero_cnt(c_zero_cnt), .overflow(c_overflow)
    );

    task automatic check(input string tag, input longint obs, input longint exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [8:0] v, input logic z);
        in_valid  = 1'b1;
        sm_r      = v;
        sm_zero_r = z;
        tick();
        in_valid  = 1'b0;
    endtask

    initial begin
        logic [8:0]  t1_beats [4];
        logic [12:0] c1_beats [4];

        rst = 1'b1;
        in_valid = 0; sm_r = 0; sm_zero_r = 0; out_ready = 0;
        v_in_valid = 0; v_sm_r = 0; v_out_ready = 0;
        c_in_valid = 0; c_sm_r = 0; c_sm_zero_r = 0; c_out_ready = 0;
        tick();
        tick();
        rst = 1'b0;

        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_acc", acc, 0);
        check("rst_zero_cnt", zero_cnt, 0);
        check("rst_overflow", overflow, 0);

        // 1: basic frame
        t1_beats = '{9'd3, 9'd5, 9'd0, 9'd7};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("t1_pre_valid", out_valid, 0);
            beat(t1_beats[i], t1_beats[i] == 0);
        end
        check("t1_out_valid", out_valid, 1);
        check("t1_acc", acc, 15);
        check("t1_zero_cnt", zero_cnt, 1);
        check("t1_overflow", overflow, 0);
        tick();
        check("t1_taken_valid", out_valid, 0);
        check("t1_taken_acc", acc, 0);
        check("t1_taken_zero", zero_cnt, 0);

        // 2: back-pressure, with in_valid pushing during HOLD
        out_ready = 1'b0;
        beat(10, 0); beat(20, 0); beat(30, 0); beat(40, 0);
        in_valid = 1'b1;
        sm_r = 9'd99;
        for (int i = 0; i < 5; i++) begin
            check("t2_out_valid", out_valid, 1);
            check("t2_in_ready", in_ready, 0);
            check("t2_acc", acc, 100);
            check("t2_zero_cnt", zero_cnt, 0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check("t2_release_valid", out_valid, 0);
        check("t2_release_ready", in_ready, 1);
        check("t2_release_acc", acc, 0);

        // 4: reset mid-frame
        beat(9, 0); beat(9, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t4_after_rst_acc", acc, 0);
        out_ready = 1'b0;
        beat(1, 0); beat(1, 0); beat(1, 0); beat(1, 0);
        check("t4_out_valid", out_valid, 1);
        check("t4_acc", acc, 4);
        check("t4_zero_cnt", zero_cnt, 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // 5: gapped input, beats 1,3,5,7 on even cycles
        for (int i = 0; i < 8; i++) begin
            in_valid  = (i % 2 == 0);
            sm_r      = 9'(i + 1);
            sm_zero_r = 1'b0;
            tick();
            check("t5_out_valid", out_valid, (i >= 6) ? 1 : 0);
        end
        in_valid = 1'b0;
        check("t5_acc", acc, 16);
        out_ready = 1'b1;
        tick();
        check("t5_taken", out_valid, 0);

        // 3: overflow on a 10-bit accumulator
        v_in_valid = 1'b1;
        v_sm_r = 9'd511;
        for (int i = 0; i < 4; i++) tick();
        v_in_valid = 1'b0;
        check("t3_out_valid", v_out_valid, 1);
`ifdef SUM_ACC_SAT_EN
        check("t3_acc_sat", v_acc, 1023);
`else
        check("t3_acc_wrap", v_acc, 1020);
`endif
        check("t3_overflow", v_overflow, 1);
        v_out_ready = 1'b1;
        tick();
        check("t3_ovf_cleared", v_overflow, 0);
        check("t3_acc_cleared", v_acc, 0);

        // 6: COUNT=1, continuous in_valid
        c1_beats = '{13'd7, 13'd0, 13'd300, 13'd511};
        c_out_ready = 1'b1;
        c_in_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            c_sm_r      = c1_beats[i][8:0];
            c_sm_zero_r = (c1_beats[i] == 0);
            tick();
            check("t6_out_valid", c_out_valid, 1);
            check("t6_acc", c_acc, c1_beats[i]);
            check("t6_zero_cnt", c_zero_cnt, (c1_beats[i] == 0) ? 1 : 0);
            tick();
            check("t6_gap", c_out_valid, 0);
        end
        c_in_valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
